// File: rtl/pmem_write_buffer.sv
// Single-entry victim write buffer between the L1 controller and main memory.
// Absorbs write-backs, serves matching fills locally, drains when L1 is idle.
module pmem_write_buffer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_resp,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  buf_hit_inc,
    output logic                  merge_inc,
    output logic                  drain_inc
);

    localparam int TW = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, RESP, FETCH, DRAIN} state_t;

    state_t                state, state_n;
    logic                  buf_valid, buf_valid_n;
    logic [TW-1:0]         buf_tag, buf_tag_n;
    logic [LINE_WIDTH-1:0] buf_data, buf_data_n;
    logic [LINE_WIDTH-1:0] rdata_n;
    logic [TW-1:0]         req_tag;
    logic                  tag_match;
    logic                  unused_offset;

    assign req_tag       = mem_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign tag_match     = buf_tag == req_tag;
    assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_n;
            buf_valid <= buf_valid_n;
            buf_tag   <= buf_tag_n;
            buf_data  <= buf_data_n;
            mem_rdata <= rdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        buf_valid_n  = buf_valid;
        buf_tag_n    = buf_tag;
        buf_data_n   = buf_data;
        rdata_n      = mem_rdata;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        buf_hit_inc  = 1'b0;
        merge_inc    = 1'b0;
        drain_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                // Reads take priority; a conflicting write must wait for the drain
                if (mem_read) begin
                    if (buf_valid && tag_match) begin
                        rdata_n     = buf_data;
                        buf_hit_inc = 1'b1;
                        state_n     = RESP;
                    end else begin
                        state_n = FETCH;
                    end
                end else if (mem_write) begin
                    if (!buf_valid || tag_match) begin
                        buf_tag_n   = req_tag;
                        buf_data_n  = mem_wdata;
                        buf_valid_n = 1'b1;
                        merge_inc   = buf_valid;
                        state_n     = RESP;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (buf_valid) begin
                    state_n = DRAIN;
                end
            end
            RESP: begin
                mem_resp = 1'b1;
                state_n  = IDLE;
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    rdata_n = pmem_rdata;
                    state_n = RESP;
                end
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {buf_tag, {OFFSET_BITS{1'b0}}};
                pmem_wdata   = buf_data;
                if (pmem_resp) begin
                    buf_valid_n = 1'b0;
                    drain_inc   = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: vector table, memory responder and
// scoreboard queues for drained lines and fill data.
module tb_pmem_write_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [127:0] mem_wdata = '0;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         buf_hit_inc;
    logic         merge_inc;
    logic         drain_inc;

    pmem_write_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .buf_hit_inc  (buf_hit_inc),
        .merge_inc    (merge_inc),
        .drain_inc    (drain_inc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
    } line_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
        int           idle;
        int           mlat;
        int           lat;
        logic         hit;
        logic         merge;
    } vec_t;

    localparam logic [127:0] D1 = {8{16'h1111}};
    localparam logic [127:0] D2 = {8{16'h2222}};
    localparam logic [127:0] D3 = {8{16'h3333}};
    localparam logic [127:0] D4 = {8{16'h4444}};
    localparam logic [127:0] D5 = {8{16'h5555}};
    localparam logic [127:0] D6 = {8{16'h6666}};
    localparam logic [127:0] D7 = {8{16'h7777}};

    int           total = 0;
    int           bad = 0;
    int           mem_lat = 3;
    int           cnt = 0;
    line_t        dq[$];
    logic [127:0] rq[$];
    logic [127:0] mem [logic [11:0]];
    vec_t         vt[13];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] memget(input logic [11:0] t);
        if (mem.exists(t)) return mem[t];
        return {8{4'hA, t}};
    endfunction

    // Main memory: fixed latency, one-cycle pmem_resp, stores drained lines.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
                chk("idle_gap", {126'b0, pmem_read, pmem_write}, '0);
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    chk("pmem_offset", {124'b0, pmem_address[3:0]}, '0);
                    if (pmem_read) begin
                        pmem_rdata = memget(pmem_address[15:4]);
                        pmem_resp = 1'b1;
                        #1 chk("drain_inc_on_read", {127'b0, drain_inc}, '0);
                    end else begin
                        if (dq.size() == 0) begin
                            chk("drain_unexpected", {116'b0, pmem_address[15:4]}, '1);
                        end else begin
                            line_t l;
                            l = dq.pop_front();
                            chk("drain_addr", {116'b0, pmem_address[15:4]}, {116'b0, l.tag});
                            chk("drain_data", pmem_wdata, l.data);
                        end
                        mem[pmem_address[15:4]] = pmem_wdata;
                        pmem_resp = 1'b1;
                        #1 chk("drain_inc", {127'b0, drain_inc}, 128'd1);
                    end
                end
            end
        end
    end

    task automatic l1_op(input vec_t v);
        logic [11:0]  tag;
        logic         hit;
        logic         mg;
        logic         got;
        int           n;
        int           rdc;
        repeat (v.idle) @(negedge clk);
        mem_lat = v.mlat;
        tag = v.addr[15:4];
        if (v.wr) begin
            if (dq.size() > 0 && dq[dq.size()-1].tag == tag &&
                !(dq.size() == 1 && pmem_write))
                dq[dq.size()-1].data = v.data;
            else
                dq.push_back('{tag, v.data});
        end else begin
            if (dq.size() > 0 && dq[dq.size()-1].tag == tag)
                rq.push_back(dq[dq.size()-1].data);
            else
                rq.push_back(memget(tag));
        end
        mem_address = v.addr;
        mem_wdata   = v.data;
        mem_write   = v.wr;
        mem_read    = !v.wr;
        #1;
        hit = buf_hit_inc;
        mg  = merge_inc;
        got = 1'b0;
        n   = 0;
        rdc = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (mem_resp) begin
                got = 1'b1;
                break;
            end
            hit |= buf_hit_inc;
            mg  |= merge_inc;
            if (pmem_read) rdc++;
        end
        chk("resp_seen", {127'b0, got}, 128'd1);
        if (got) begin
            chk("resp_latency", 128'(n), 128'(v.lat));
            chk("hit_inc", {127'b0, hit}, {127'b0, v.hit});
            chk("merge_inc", {127'b0, mg}, {127'b0, v.merge});
            if (!v.wr) begin
                chk("fill_data", mem_rdata, rq.pop_front());
                chk("pmem_read_cycles", 128'(rdc), v.hit ? '0 : 128'(v.mlat));
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_resp", {127'b0, mem_resp}, '0);
        chk("rst_mem_rdata", mem_rdata, '0);
        chk("rst_pmem_strobes", {126'b0, pmem_read, pmem_write}, '0);
        chk("rst_pmem_address", {112'b0, pmem_address}, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_incs", {125'b0, buf_hit_inc, merge_inc, drain_inc}, '0);
    endtask

    initial begin
        int   n;
        int   wr_seen;
        vec_t v;
        vt[0]  = '{1'b1, 16'h1230, D1,  0, 3, 1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 16'h1234, '0,  0, 3, 2, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 16'h1238, D2,  0, 3, 2, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 16'h4560, D3,  0, 3, 6, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 16'h7770, '0, 10, 5, 6, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 16'h4562, '0,  0, 3, 5, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 16'h0000, D4,  0, 3, 2, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 16'hFFF0, D5,  0, 3, 6, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 16'hFFFE, '0,  0, 3, 2, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 16'hFFF8, D6,  0, 3, 2, 1'b0, 1'b1};
        vt[10] = '{1'b0, 16'h0008, '0, 20, 3, 4, 1'b0, 1'b0};
        vt[11] = '{1'b0, 16'hFFF0, '0,  0, 3, 5, 1'b0, 1'b0};
        vt[12] = '{1'b1, 16'h2220, D7,  2, 3, 1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_outs();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) l1_op(vt[i]);

        // Reset while a drain is in flight discards the buffered line.
        l1_op(vt[12]);
        n = 0;
        while (n < 20 && !pmem_write) begin
            @(negedge clk);
            n++;
        end
        chk("drain_started", {127'b0, pmem_write}, 128'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        reset = 1'b0;
        dq.delete();
        rq.delete();
        wr_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (pmem_write) wr_seen++;
        end
        chk("no_drain_after_reset", 128'(wr_seen), '0);

        v = '{1'b0, 16'h2220, '0, 0, 3, 4, 1'b0, 1'b0};
        l1_op(v);
        repeat (5) @(negedge clk);
        chk("drain_queue_empty", 128'(dq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
